// File: rtl/dmx_rx_frame.sv
// DMX512 frame receiver: tracks break/start code/slots from a UART byte stream and
// strobes writes for slots in a channel window. Optional inter-slot timeout: DMX_RX_TIMEOUT_EN.
module dmx_rx_frame #(
   parameter logic [7:0] START_CODE   = 8'h00,
   parameter int         NUM_CHANNELS = 16,
   parameter int         TIMEOUT_CLKS = 16000000
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_DV,
   input  logic [7:0] i_Rx_Byte,
   input  logic       i_Rx_Break,
   input  logic [9:0] i_Start_Addr,
   output logic       o_Wr_En,
   output logic [8:0] o_Wr_Addr,
   output logic [7:0] o_Wr_Data,
   output logic       o_Frame_Done,
   output logic [9:0] o_Slot_Count
);

   typedef enum logic [1:0] {IDLE, START, SLOTS, IGNORE} state_t;

   state_t     r_state, state_n;
   logic [9:0] r_start, start_n;
   logic [9:0] r_slot, slot_n;
   logic       wr_en_n, done_n;
   logic [8:0] wr_addr_n;
   logic [7:0] wr_data_n;
   logic [9:0] count_n;
   logic       timeout;

   logic [9:0]  slot_inc;
   logic [10:0] win_hi;
   logic        start_ok, in_win;
   logic [9:0]  offset;

   assign slot_inc = r_slot + 10'd1;
   assign win_hi   = {1'b0, r_start} + 11'(NUM_CHANNELS - 1);
   // out-of-range start addresses yield an empty window
   assign start_ok = (r_start >= 10'd1) && (r_start <= 10'd512);
   assign in_win   = start_ok && (slot_inc >= r_start) && ({1'b0, slot_inc} <= win_hi);
   assign offset   = slot_inc - r_start;

`ifdef DMX_RX_TIMEOUT_EN
   logic [23:0] r_to_cnt;
   logic        to_active;

   assign to_active = (r_state == SLOTS) || (r_state == START);
   assign timeout   = to_active && (r_to_cnt == 24'(TIMEOUT_CLKS - 1));

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset)
         r_to_cnt <= '0;
      else if (!to_active || i_Rx_DV || i_Rx_Break || timeout)
         r_to_cnt <= '0;
      else
         r_to_cnt <= r_to_cnt + 24'd1;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CLKS != 0);
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_n   = r_state;
      start_n   = r_start;
      slot_n    = r_slot;
      wr_en_n   = 1'b0;
      wr_addr_n = o_Wr_Addr;
      wr_data_n = o_Wr_Data;
      done_n    = 1'b0;
      count_n   = o_Slot_Count;
      // a break always restarts the frame and drops any coincident byte
      if (i_Rx_Break) begin
         start_n = i_Start_Addr;
         slot_n  = '0;
         state_n = START;
         if (r_state == SLOTS) begin
            done_n  = 1'b1;
            count_n = r_slot;
         end
      end else begin
         case (r_state)
            IDLE: ;
            START: begin
               if (i_Rx_DV)
                  state_n = (i_Rx_Byte == START_CODE) ? SLOTS : IGNORE;
               else if (timeout)
                  state_n = IDLE;
            end
            SLOTS: begin
               if (i_Rx_DV) begin
                  slot_n = slot_inc;
                  if (in_win) begin
                     wr_en_n   = 1'b1;
                     wr_addr_n = offset[8:0];
                     wr_data_n = i_Rx_Byte;
                  end
                  if (slot_inc == 10'd512) begin
                     done_n  = 1'b1;
                     count_n = slot_inc;
                     state_n = IDLE;
                  end
               end else if (timeout) begin
                  done_n  = 1'b1;
                  count_n = r_slot;
                  state_n = IDLE;
               end
            end
            IGNORE: ;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_state      <= IDLE;
         r_start      <= '0;
         r_slot       <= '0;
         o_Wr_En      <= 1'b0;
         o_Wr_Addr    <= '0;
         o_Wr_Data    <= '0;
         o_Frame_Done <= 1'b0;
         o_Slot_Count <= '0;
      end else begin
         r_state      <= state_n;
         r_start      <= start_n;
         r_slot       <= slot_n;
         o_Wr_En      <= wr_en_n;
         o_Wr_Addr    <= wr_addr_n;
         o_Wr_Data    <= wr_data_n;
         o_Frame_Done <= done_n;
         o_Slot_Count <= count_n;
      end
   end

endmodule

// File: tb/tb_dmx_rx_frame.sv
// Directed bench for dmx_rx_frame: writes and frame-done events are logged on the
// falling edge and compared against hand-computed expectations per scenario.
module tb_dmx_rx_frame;

   logic       i_Clock = 1'b0;
   logic       i_Reset = 1'b1;
   logic       i_Rx_DV = 1'b0;
   logic [7:0] i_Rx_Byte = 8'h00;
   logic       i_Rx_Break = 1'b0;
   logic [9:0] i_Start_Addr = 10'd1;
   logic       o_Wr_En;
   logic [8:0] o_Wr_Addr;
   logic [7:0] o_Wr_Data;
   logic       o_Frame_Done;
   logic [9:0] o_Slot_Count;

   int passes = 0;
   int total  = 0;

   logic [8:0] wa_q[$];
   logic [7:0] wd_q[$];
   logic [9:0] dc_q[$];
   logic       dw_q[$];

   dmx_rx_frame #(.START_CODE(8'h00), .NUM_CHANNELS(16), .TIMEOUT_CLKS(100)) dut (
      .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
      .i_Rx_Break(i_Rx_Break), .i_Start_Addr(i_Start_Addr), .o_Wr_En(o_Wr_En),
      .o_Wr_Addr(o_Wr_Addr), .o_Wr_Data(o_Wr_Data), .o_Frame_Done(o_Frame_Done),
      .o_Slot_Count(o_Slot_Count));

   always #5 i_Clock = ~i_Clock;

   always @(negedge i_Clock) begin
      if (o_Wr_En) begin
         wa_q.push_back(o_Wr_Addr);
         wd_q.push_back(o_Wr_Data);
      end
      if (o_Frame_Done) begin
         dc_q.push_back(o_Slot_Count);
         dw_q.push_back(o_Wr_En);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge i_Clock);
   endtask

   task automatic clear_logs();
      wa_q.delete(); wd_q.delete(); dc_q.delete(); dw_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge i_Clock);
      i_Rx_DV = 1'b1; i_Rx_Byte = b;
      @(negedge i_Clock);
      i_Rx_DV = 1'b0;
   endtask

   task automatic send_break(input logic [9:0] sa);
      @(negedge i_Clock);
      i_Start_Addr = sa; i_Rx_Break = 1'b1;
      @(negedge i_Clock);
      i_Rx_Break = 1'b0;
   endtask

   task automatic test_reset();
      i_Reset = 1'b1;
      idle(3);
      if ({o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Frame_Done, o_Slot_Count} !== 29'd0)
         $display("FAIL reset_outputs: got %h want 0",
                  {o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Frame_Done, o_Slot_Count});
      else passes++;
      total++;
      i_Reset = 1'b0;
      idle(2);
      clear_logs();
   endtask

   task automatic test_window();
      send_break(10'd5);
      send_byte(8'h00);
      for (int s = 1; s <= 20; s++) send_byte(8'(s));
      send_break(10'd5);
      idle(3);
      if (wa_q.size() !== 16) $display("FAIL win_count: got %0d want 16", wa_q.size());
      else passes++;
      total++;
      for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
         if (wa_q[i] !== 9'(i) || wd_q[i] !== 8'(i + 5))
            $display("FAIL win_write%0d: got addr %0d data %h want addr %0d data %h",
                     i, wa_q[i], wd_q[i], i, 8'(i + 5));
         else passes++;
         total++;
      end
      if (dc_q.size() !== 1 || dc_q[0] !== 10'd20)
         $display("FAIL win_done: got %0d pulses count %0d want 1 pulse count 20",
                  dc_q.size(), (dc_q.size() > 0) ? dc_q[0] : 10'd0);
      else passes++;
      total++;
      clear_logs();
   endtask

   task automatic test_bad_start_code();
      send_break(10'd1);
      send_byte(8'hCC);
      for (int s = 1; s <= 10; s++) send_byte(8'(s + 16));
      send_break(10'd1);
      idle(3);
      if (wa_q.size() !== 0 || dc_q.size() !== 0)
         $display("FAIL bad_sc_silent: got %0d writes %0d done want 0 0", wa_q.size(), dc_q.size());
      else passes++;
      total++;
      send_byte(8'h00);
      send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
      send_break(10'd1);
      idle(3);
      if (wa_q.size() !== 3 || wa_q[2] !== 9'd2 || wd_q[2] !== 8'hA3)
         $display("FAIL bad_sc_recover: got %0d writes last %0d/%h want 3 writes last 2/a3",
                  wa_q.size(), (wa_q.size() > 2) ? wa_q[2] : 9'd0, (wd_q.size() > 2) ? wd_q[2] : 8'd0);
      else passes++;
      total++;
      if (dc_q.size() !== 1 || dc_q[0] !== 10'd3)
         $display("FAIL bad_sc_recover_done: got %0d pulses want 1 count 3", dc_q.size());
      else passes++;
      total++;
      clear_logs();
   endtask

   task automatic test_full_frame();
      logic [8:0] ea[3];
      logic [7:0] ed[3];
      ea = '{9'd0, 9'd1, 9'd2};
      ed = '{8'hFE, 8'hFF, 8'h00};
      send_break(10'd510);
      send_byte(8'h00);
      for (int s = 1; s <= 512; s++) send_byte(8'(s));
      idle(2);
      if (wa_q.size() !== 3) $display("FAIL full_count: got %0d want 3", wa_q.size());
      else passes++;
      total++;
      for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
         if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i])
            $display("FAIL full_write%0d: got %0d/%h want %0d/%h", i, wa_q[i], wd_q[i], ea[i], ed[i]);
         else passes++;
         total++;
      end
      if (dc_q.size() !== 1 || dc_q[0] !== 10'd512 || dw_q[0] !== 1'b1)
         $display("FAIL full_done: got %0d pulses count %0d with_wr %b want 1 512 1",
                  dc_q.size(), (dc_q.size() > 0) ? dc_q[0] : 10'd0, (dw_q.size() > 0) ? dw_q[0] : 1'b0);
      else passes++;
      total++;
      clear_logs();
      send_byte(8'h55);
      idle(3);
      if (wa_q.size() !== 0 || dc_q.size() !== 0)
         $display("FAIL full_after: got %0d writes %0d done want 0 0", wa_q.size(), dc_q.size());
      else passes++;
      total++;
      if (o_Slot_Count !== 10'd512) $display("FAIL count_hold: got %0d want 512", o_Slot_Count);
      else passes++;
      total++;
      clear_logs();
   endtask

   task automatic test_break_collision();
      send_break(10'd1);
      send_byte(8'h00);
      for (int s = 1; s <= 7; s++) send_byte(8'(s + 8'h40));
      @(negedge i_Clock);
      i_Rx_DV = 1'b1; i_Rx_Byte = 8'h99; i_Rx_Break = 1'b1; i_Start_Addr = 10'd1;
      @(negedge i_Clock);
      i_Rx_DV = 1'b0; i_Rx_Break = 1'b0;
      idle(2);
      if (wa_q.size() !== 7) $display("FAIL coll_writes: got %0d want 7", wa_q.size());
      else passes++;
      total++;
      if (dc_q.size() !== 1 || dc_q[0] !== 10'd7)
         $display("FAIL coll_done: got %0d pulses count %0d want 1 7",
                  dc_q.size(), (dc_q.size() > 0) ? dc_q[0] : 10'd0);
      else passes++;
      total++;
      clear_logs();
      send_byte(8'h00);
      send_byte(8'h77);
      send_break(10'd1);
      idle(2);
      if (wa_q.size() !== 1 || wa_q[0] !== 9'd0 || wd_q[0] !== 8'h77 || dc_q.size() !== 1 || dc_q[0] !== 10'd1)
         $display("FAIL coll_restart: got %0d writes %0d done want 1 write 0/77 and count 1",
                  wa_q.size(), dc_q.size());
      else passes++;
      total++;
      clear_logs();
   endtask

   task automatic test_empty_window();
      send_break(10'd600);
      send_byte(8'h00);
      for (int s = 1; s <= 5; s++) send_byte(8'hE0);
      send_break(10'd0);
      send_byte(8'h00);
      send_byte(8'hE1);
      send_break(10'd1);
      idle(2);
      if (wa_q.size() !== 0) $display("FAIL empty_writes: got %0d want 0", wa_q.size());
      else passes++;
      total++;
      if (dc_q.size() !== 2 || dc_q[0] !== 10'd5 || dc_q[1] !== 10'd1)
         $display("FAIL empty_done: got %0d pulses want 2 with counts 5,1", dc_q.size());
      else passes++;
      total++;
      clear_logs();
   endtask

   task automatic test_reset_midframe();
      i_Reset = 1'b1; idle(2); i_Reset = 1'b0; idle(1);
      clear_logs();
      send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
      idle(2);
      if (wa_q.size() !== 0 || dc_q.size() !== 0)
         $display("FAIL pre_break: got %0d writes %0d done want 0 0", wa_q.size(), dc_q.size());
      else passes++;
      total++;
      send_break(10'd1);
      send_byte(8'h00);
      send_byte(8'h31);
      send_byte(8'h33);
      #2 i_Reset = 1'b1;
      #1;
      if ({o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Frame_Done, o_Slot_Count} !== 29'd0)
         $display("FAIL async_reset: got %h want 0",
                  {o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Frame_Done, o_Slot_Count});
      else passes++;
      total++;
      idle(2);
      i_Reset = 1'b0;
      clear_logs();
      send_break(10'd1);
      idle(3);
      if (dc_q.size() !== 0) $display("FAIL reset_no_done: got %0d pulses want 0", dc_q.size());
      else passes++;
      total++;
      clear_logs();
   endtask

   task automatic test_timeout();
      int k;
      bit seen;
      send_break(10'd1);
      send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      k = 0; seen = 1'b0;
      while (!seen && k < 200) begin
         @(negedge i_Clock);
         k++;
         if (o_Frame_Done) seen = 1'b1;
      end
`ifdef DMX_RX_TIMEOUT_EN
      if (!seen || k !== 100 || o_Slot_Count !== 10'd3)
         $display("FAIL timeout_done: got seen %0b after %0d clks count %0d want 1 100 3",
                  seen, k, o_Slot_Count);
      else passes++;
      total++;
`else
      if (seen) $display("FAIL no_timeout: got pulse after %0d clks want none", k);
      else passes++;
      total++;
`endif
      clear_logs();
   endtask

   initial begin
      test_reset();
      test_window();
      test_bad_start_code();
      test_full_frame();
      test_break_collision();
      test_empty_window();
      test_reset_midframe();
      test_timeout();
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
